imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words in instruction memory.
REQ-002 The block SHALL have parameter AW, default 8, meaning the instruction memory byte-address width (2^AW = 4*DEPTH).
REQ-003 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 The block SHALL have port byte_valid  input  1  host byte present.
REQ-007 The block SHALL have port byte_data  input  8  host byte.
REQ-008 The block SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-009 The block SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 The block SHALL have port imem_addr  output  AW  instruction-memory byte address, word aligned.
REQ-011 The block SHALL have port imem_wdata  output  32  instruction word to write.
REQ-012 The block SHALL have port cpu_reset  output  1  holds the processor (program counter, register file) in reset.
REQ-013 The block SHALL have ports busy, done and err  output  1 each  load status flags.
REQ-014 The block SHALL have port words_loaded  output  16  count of words written in the current load.

Function
REQ-015 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1.
REQ-016 byte_ready SHALL be 1 in states LEN_LO, LEN_HI and DATA, and 0 otherwise.
REQ-017 The FSM SHALL use states IDLE, LEN_LO, LEN_HI, DATA, DONE and ERROR.
REQ-018 Transitions:
- start in IDLE, DONE or ERROR -> LEN_LO, clearing done, err and words_loaded.
- start in any other state SHALL be ignored.
REQ-019 Word count N:
- LEN_LO SHALL capture byte as N[7:0], then go to LEN_HI.
- LEN_HI SHALL capture byte as N[15:8].
REQ-020 From LEN_HI, N=0 or N>DEPTH SHALL go to ERROR; otherwise the FSM SHALL go to DATA.
REQ-021 In DATA, byte k (k=0..3, mod 4) of each word SHALL land in bits [8k+7:8k] (little-endian).
REQ-022 Acceptance of the 4th byte of word i SHALL produce imem_we=1 for exactly the next cycle, with imem_addr=4*i and imem_wdata = the assembled word.
REQ-023 words_loaded SHALL increment on the same cycle imem_we is asserted.
REQ-024 byte_ready SHALL stay 1 during the imem_we cycle (no bubble), so back-to-back words SHALL write on consecutive 4-cycle boundaries.
REQ-025 After the 4th byte of word N-1 is accepted, the FSM SHALL enter DONE; the final imem_we SHALL occur in the first DONE cycle.
REQ-026 cpu_reset SHALL deassert one cycle after the final imem_we.
REQ-027 cpu_reset SHALL be 1 in IDLE, LEN_LO, LEN_HI, DATA and ERROR; it SHALL be 0 only in DONE after the cycle in REQ-026.
REQ-028 Status flags:
- busy SHALL be 1 in LEN_LO, LEN_HI and DATA.
- done SHALL be 1 in DONE.
- err SHALL be 1 in ERROR.
REQ-029 In ERROR, no imem_we SHALL occur and words_loaded SHALL hold 0.
REQ-030 imem_addr SHALL wrap never: by REQ-020 i is at most DEPTH-1, so addresses SHALL stay in range.
REQ-031 byte_valid with byte_ready=0 SHALL be ignored, and the byte SHALL NOT be buffered.
REQ-032 start asserted in DONE SHALL reassert cpu_reset on the next cycle and begin a new load.

Reset
REQ-033 On reset=1 at a clock edge, the block SHALL enter IDLE and set:
- cpu_reset=1
- byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
- busy=0, done=0, err=0, words_loaded=0
REQ-034 Reset mid-load SHALL abort immediately: no imem_we SHALL follow, and a partially assembled word SHALL be discarded.
REQ-035 Reset SHALL take priority over start and byte transfers in the same cycle.

Verification
REQ-036 Load of 2 words: start; bytes 02 00 13 05 50 00 B3 05 B5 00 ->
- write 0x00500513 @0
- write 0x00B505B3 @4
- words_loaded=2, done=1
- cpu_reset falls one cycle after the second write.
REQ-037 Length out of range: N=0 (bytes 00 00) and N=DEPTH+1 -> err=1, no imem_we, cpu_reset stays 1.
REQ-038 Valid gaps: byte_valid toggled randomly during a 3-word load -> identical writes and addresses 0,4,8 as the gap-free run.
REQ-039 Reset after 6 data bytes of a 2-word load -> exactly one write (word 0), then IDLE, words_loaded=0, cpu_reset=1.
REQ-040 Reload: after DONE, start plus a 1-word load of 0x00000013 -> cpu_reset=1 during the load, write @0, then done=1; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed byte image into instruction memory
//
// Host protocol: after a start pulse the loader takes a 16-bit little-endian
// word count N, then N*4 little-endian data bytes. Each completed word is written
// to instruction memory at byte address 4*i. The processor is held in reset
// until the whole image has been written.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start              single-cycle request to begin a load
//   byte_valid/data    host byte stream, accepted when byte_ready is high
//   byte_ready         loader accepts a byte this cycle
//   imem_we/addr/wdata instruction-memory write port (one-cycle strobe per word)
//   cpu_reset          holds the processor in reset while loading or after an error
//   busy, done, err    load status flags
//   words_loaded       words written during the current load

module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] partial;

    logic        xfer;
    logic        can_start;
    logic        word_done;
    logic        last_word;
    logic [15:0] len_full;
    logic        len_bad;

    assign xfer      = byte_valid && byte_ready;
    assign can_start = start && (state == IDLE || state == DONE || state == ERROR);
    assign word_done = xfer && (state == DATA) && (byte_idx == 2'd3);
    // words_loaded still holds the index of the word being completed
    assign last_word = (words_loaded + 16'd1) == word_cnt;
    assign len_full  = {byte_data, word_cnt[7:0]};
    assign len_bad   = (len_full == 16'd0) || (len_full > DEPTH_W);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_nxt = len_bad ? ERROR : DATA;
            end
            DATA: begin
                if (word_done && last_word) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs. The final write strobe lands in the first DONE
    // cycle, so the processor is released only once imem_we has dropped.
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_reset  = 1'b1;
        case (state)
            LEN_LO, LEN_HI, DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                cpu_reset = imem_we;
            end
            ERROR: begin
                err = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

    // Datapath: length capture, word assembly and the memory write port
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt     <= 16'd0;
            byte_idx     <= 2'd0;
            partial      <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= word_done;

            if (can_start) begin
                words_loaded <= 16'd0;
                byte_idx     <= 2'd0;
                partial      <= 24'd0;
            end

            if (xfer && state == LEN_LO) word_cnt[7:0]  <= byte_data;
            if (xfer && state == LEN_HI) word_cnt[15:8] <= byte_data;

            if (xfer && state == DATA) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: partial[7:0]   <= byte_data;
                    2'd1: partial[15:8]  <= byte_data;
                    2'd2: partial[23:16] <= byte_data;
                    default: begin
                        imem_wdata   <= {byte_data, partial};
                        imem_addr    <= {words_loaded[AW-3:0], 2'b00};
                        words_loaded <= words_loaded + 16'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard testbench for imem_loader

module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   words_loaded;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [15:0]   cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ld_words[$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    // Monitor: every write strobe must match the oldest expected write
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_we: got addr %h data %h expected no write at %0t",
                             imem_addr, imem_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("we_addr", 32'(imem_addr), 32'(e.addr));
                    chk("we_data", imem_wdata, e.data);
                    chk("we_count", 32'(words_loaded), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic pulse_start();
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte, optionally with random idle gaps; returns after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
        bit sent  = 1'b0;
        int tries = 0;
        while (!sent && tries < 64) begin
            @(negedge clk);
            start      = 1'b0;
            byte_valid = 1'b0;
            if (!(gaps && $urandom_range(0, 2) == 0)) begin
                byte_valid = 1'b1;
                byte_data  = b;
                start      = with_start;
                if (byte_ready === 1'b1) sent = 1'b1;
            end
            tries++;
        end
        if (sent) begin
            @(posedge clk);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept: got byte_ready stuck low expected accept at %0t", $time);
        end
    endtask

    // Load ld_words; the model is the byte stream itself: LE count then LE words
    task automatic do_load(input bit gaps, input bit start_mid);
        int          n;
        exp_t        e;
        logic [31:0] w;
        logic [15:0] n16;
        n   = ld_words.size();
        n16 = 16'(n);
        pulse_start();
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("load_done_clr", 32'(done), 32'd0);
        chk("load_cnt_clr", 32'(words_loaded), 32'd0);
        for (int i = 0; i < n; i++) begin
            e.addr = AW'(4 * i);
            e.data = ld_words[i];
            e.cnt  = 16'(i + 1);
            exp_q.push_back(e);
        end
        send_byte(n16[7:0], gaps, 1'b0);
        send_byte(n16[15:8], gaps, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = ld_words[i];
            for (int k = 0; k < 4; k++)
                send_byte(w[8*k +: 8], gaps, start_mid && i == 0 && k == 1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
        chk("final_we", 32'(imem_we), 32'd1);
        chk("final_done", 32'(done), 32'd1);
        chk("final_cpu_reset_held", 32'(cpu_reset), 32'd1);
        chk("final_count", 32'(words_loaded), 32'(n));
        @(negedge clk);
        chk("release_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("release_done", 32'(done), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_err(input logic [15:0] len);
        pulse_start();
        send_byte(len[7:0], 1'b0, 1'b0);
        send_byte(len[15:8], 1'b0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("err_flag", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_done", 32'(done), 32'd0);
        chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("err_count", 32'(words_loaded), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            chk("err_ready", 32'(byte_ready), 32'd0);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        chk("err_hold", 32'(err), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_count"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        reset      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        start      = 1'b0;
        byte_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        check_idle("idle");

        // Two-word reference image
        ld_words = '{32'h00500513, 32'h00B505B3};
        do_load(1'b0, 1'b0);

        // Same three words without and with valid gaps
        ld_words = '{$urandom, $urandom, $urandom};
        do_load(1'b0, 1'b0);
        do_load(1'b1, 1'b0);

        // Reload from DONE; start pulsed mid-load is ignored
        ld_words = '{32'h00000013};
        do_load(1'b0, 1'b1);

        // Out-of-range lengths, then recovery from ERROR
        do_err(16'd0);
        do_err(16'(DEPTH + 1));
        do_err(16'h0100);

        for (int t = 0; t < 5; t++) begin
            ld_words.delete();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) ld_words.push_back($urandom);
            do_load(1'($urandom), 1'b0);
        end

        // Full memory
        ld_words.delete();
        for (int i = 0; i < DEPTH; i++) ld_words.push_back($urandom);
        do_load(1'b1, 1'b0);

        // Reset after six data bytes of a two-word load
        pulse_start();
        e.addr = '0;
        e.data = 32'hCAFE0123;
        e.cnt  = 16'd1;
        exp_q.push_back(e);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h23, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'hFE, 1'b0, 1'b0);
        send_byte(8'hCA, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        @(negedge clk);
        reset      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        chk("abort_outstanding", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
